// File: rtl/br_pred.sv
// rtl/br_pred.sv - gshare conditional-branch predictor with resolution-time training
module br_pred #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic [63:0]      f_pc,
  input  logic [31:0]      f_ir,
  output logic             pr_taken,
  output logic [63:0]      pr_addr,
  output logic [IDX_W-1:0] pr_idx,
  input  logic             u_branch,
  input  logic [IDX_W-1:0] u_idx,
  input  logic             u_pr_taken,
  input  logic             u_pr_miss,
  output logic [31:0]      stat_br,
  output logic [31:0]      stat_miss
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ghr;
  logic [1:0]       pht [DEPTH];

  logic             run;
  logic             is_br;
  logic [63:0]      br_off;
  logic             upd;
  logic             actual;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nx;
  logic             unused_ir;

  // Instruction bits that play no part in branch detection or target decode
  assign unused_ir = ^f_ir[24:12];

  // State register; reset always restarts table initialisation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  // Next state: leave INIT once the last table entry has been written
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_INIT: if (ptr == '1) state_nx = S_RUN;
      S_RUN:  ready = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

  assign run = (state == S_RUN);

  // Init pointer sweeps the table once after each reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= '0;
    else if (state == S_INIT) ptr <= ptr + 1'b1;
  end

  // Training: resolved direction is the carried prediction corrected by the miss flag
  assign upd     = run & u_branch;
  assign actual  = u_pr_taken ^ u_pr_miss;
  assign ctr_cur = pht[u_idx];
  assign ctr_nx  = actual ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01)
                          : ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01);

  // Pattern table: filled with weakly-not-taken during INIT, trained in RUN
  always_ff @(posedge clk) begin
    if (state == S_INIT) pht[ptr]   <= 2'b01;
    else if (upd)        pht[u_idx] <= ctr_nx;
  end

  // Global history shifts only on resolved branches, never speculatively
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ghr <= '0;
    else if (upd) ghr <= {ghr[IDX_W-2:0], actual};
  end

  // Branch and mispredict counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br   <= '0;
      stat_miss <= '0;
    end else if (upd) begin
      stat_br   <= stat_br + 32'd1;
      stat_miss <= stat_miss + {31'd0, u_pr_miss};
    end
  end

  // Fetch-side prediction reads table and history before this edge's write
  assign is_br    = (f_ir[6:0] == 7'b1100011);
  assign pr_idx   = f_pc[IDX_W+1:2] ^ ghr;
  assign pr_taken = run & is_br & pht[pr_idx][1];
  assign br_off   = {{51{f_ir[31]}}, f_ir[31], f_ir[7], f_ir[30:25], f_ir[11:8], 1'b0};
  assign pr_addr  = pr_taken ? (f_pc + br_off) : (f_pc + 64'd4);

endmodule

// File: tb/tb_br_pred.sv
// tb/tb_br_pred.sv - directed self-checking bench for br_pred
module tb_br_pred;

  localparam int IDX_W = 6;
  localparam logic [31:0] BEQ40  = 32'h0400_0063;
  localparam logic [31:0] BNE_M8 = 32'hFE00_1CE3;
  localparam logic [31:0] ADDI   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ready;
  logic [63:0]      f_pc = 64'h0;
  logic [31:0]      f_ir = 32'h0;
  logic             pr_taken;
  logic [63:0]      pr_addr;
  logic [IDX_W-1:0] pr_idx;
  logic             u_branch = 1'b0;
  logic [IDX_W-1:0] u_idx = '0;
  logic             u_pr_taken = 1'b0;
  logic             u_pr_miss = 1'b0;
  logic [31:0]      stat_br;
  logic [31:0]      stat_miss;

  int n_cmp = 0;
  int n_mis = 0;
  logic [IDX_W-1:0] ghr_m = '0;
  int exp_br = 0;
  int exp_miss = 0;

  br_pred #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .f_pc(f_pc), .f_ir(f_ir),
    .pr_taken(pr_taken), .pr_addr(pr_addr), .pr_idx(pr_idx),
    .u_branch(u_branch), .u_idx(u_idx), .u_pr_taken(u_pr_taken), .u_pr_miss(u_pr_miss),
    .stat_br(stat_br), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [31:0] ir);
    f_pc = pc;
    f_ir = ir;
    #1;
  endtask

  function automatic logic [63:0] pc_for(input logic [IDX_W-1:0] idx);
    return 64'h1000 | {56'd0, idx ^ ghr_m, 2'b00};
  endfunction

  task automatic upd(input logic [IDX_W-1:0] idx, input logic taken, input logic miss);
    u_branch   = 1'b1;
    u_idx      = idx;
    u_pr_taken = taken ^ miss;
    u_pr_miss  = miss;
    tick();
    u_branch   = 1'b0;
    ghr_m      = {ghr_m[IDX_W-2:0], taken};
    exp_br++;
    exp_miss  += int'(miss);
  endtask

  task automatic clear_ghr;
    for (int i = 0; i < IDX_W; i++) upd(IDX_W'(50 + i), 1'b0, 1'b0);
  endtask

  task automatic init_wait(input int pre);
    repeat (pre) tick();
    fetch(64'h1000, BEQ40);
    chk("init_pr_taken", {63'd0, pr_taken}, 64'd0);
    chk("init_pr_addr", pr_addr, 64'h1004);
    repeat (63 - pre) tick();
    u_branch = 1'b0; u_pr_taken = 1'b0; u_pr_miss = 1'b0;
    chk("init_ready_lo", {63'd0, ready}, 64'd0);
    tick();
    chk("init_ready_hi", {63'd0, ready}, 64'd1);
  endtask

  initial begin
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_stat_br", {32'd0, stat_br}, 64'd0);
    chk("rst_stat_miss", {32'd0, stat_miss}, 64'd0);
    tick(); tick();
    u_branch = 1'b1; u_idx = '0; u_pr_taken = 1'b1; u_pr_miss = 1'b1;
    rst_n = 1'b1;
    init_wait(10);
    chk("init_stat_br", {32'd0, stat_br}, 64'd0);
    chk("init_stat_miss", {32'd0, stat_miss}, 64'd0);

    for (int i = 0; i < 64; i++) begin
      fetch(64'(i) << 2, BEQ40);
      chk("all_weak_nt", {63'd0, pr_taken}, 64'd0);
    end
    fetch(64'h1000, BEQ40);
    chk("train0_idx", {58'd0, pr_idx}, 64'd0);
    chk("train0_addr", pr_addr, 64'h1004);

    upd(6'd0, 1'b1, 1'b1);
    upd(6'd0, 1'b1, 1'b1);
    fetch(64'h1000, BEQ40);
    chk("train_ghr_idx", {58'd0, pr_idx}, 64'd3);
    chk("train_ghr_nt", {63'd0, pr_taken}, 64'd0);
    clear_ghr();
    fetch(64'h1000, BEQ40);
    chk("train_idx0", {58'd0, pr_idx}, 64'd0);
    chk("train_taken", {63'd0, pr_taken}, 64'd1);
    chk("train_addr", pr_addr, 64'h1040);

    repeat (5) upd(6'd5, 1'b1, 1'b0);
    upd(6'd5, 1'b0, 1'b0);
    fetch(pc_for(6'd5), BEQ40);
    chk("sat_idx", {58'd0, pr_idx}, 64'd5);
    chk("sat_hi_taken", {63'd0, pr_taken}, 64'd1);
    chk("sat_hi_addr", pr_addr, pc_for(6'd5) + 64'h40);
    upd(6'd5, 1'b0, 1'b0);
    upd(6'd5, 1'b0, 1'b0);
    fetch(pc_for(6'd5), BEQ40);
    chk("sat_zero", {63'd0, pr_taken}, 64'd0);
    upd(6'd5, 1'b0, 1'b0);
    upd(6'd5, 1'b0, 1'b0);
    fetch(pc_for(6'd5), BEQ40);
    chk("sat_floor", {63'd0, pr_taken}, 64'd0);
    upd(6'd5, 1'b1, 1'b0);
    fetch(pc_for(6'd5), BEQ40);
    chk("sat_up1", {63'd0, pr_taken}, 64'd0);
    upd(6'd5, 1'b1, 1'b0);
    fetch(pc_for(6'd5), BEQ40);
    chk("sat_up2", {63'd0, pr_taken}, 64'd1);

    upd(6'd1, 1'b1, 1'b0);
    upd(6'd1, 1'b1, 1'b0);
    clear_ghr();
    fetch(64'h4, BNE_M8);
    chk("neg_idx", {58'd0, pr_idx}, 64'd1);
    chk("neg_taken", {63'd0, pr_taken}, 64'd1);
    chk("neg_wrap_addr", pr_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(64'h4, ADDI);
    chk("nonbr_taken", {63'd0, pr_taken}, 64'd0);
    chk("nonbr_addr", pr_addr, 64'h8);

    fetch(pc_for(6'd9), BEQ40);
    u_branch = 1'b1; u_idx = 6'd9; u_pr_taken = 1'b1; u_pr_miss = 1'b0;
    #1;
    chk("hz_idx", {58'd0, pr_idx}, 64'd9);
    chk("hz_old", {63'd0, pr_taken}, 64'd0);
    tick();
    u_branch = 1'b0;
    ghr_m = {ghr_m[IDX_W-2:0], 1'b1};
    exp_br++;
    fetch(pc_for(6'd9), BEQ40);
    chk("hz_new_idx", {58'd0, pr_idx}, 64'd9);
    chk("hz_new", {63'd0, pr_taken}, 64'd1);

    chk("run_stat_br", {32'd0, stat_br}, 64'(exp_br));
    chk("run_stat_miss", {32'd0, stat_miss}, 64'(exp_miss));

    rst_n = 1'b0;
    #1;
    chk("async_ready", {63'd0, ready}, 64'd0);
    chk("async_stat_br", {32'd0, stat_br}, 64'd0);
    chk("async_stat_miss", {32'd0, stat_miss}, 64'd0);
    tick();
    u_branch = 1'b1; u_idx = '0; u_pr_taken = 1'b1; u_pr_miss = 1'b0;
    rst_n = 1'b1;
    ghr_m = '0; exp_br = 0; exp_miss = 0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_init_ready", {63'd0, ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    init_wait(30);
    chk("reinit_stat_br", {32'd0, stat_br}, 64'd0);
    chk("reinit_stat_miss", {32'd0, stat_miss}, 64'd0);
    fetch(64'h1000, BEQ40);
    chk("reinit_idx", {58'd0, pr_idx}, 64'd0);
    chk("reinit_c0", {63'd0, pr_taken}, 64'd0);
    chk("reinit_c0_addr", pr_addr, 64'h1004);
    fetch(64'h4, BNE_M8);
    chk("reinit_c1", {63'd0, pr_taken}, 64'd0);
    chk("reinit_c1_addr", pr_addr, 64'h8);

    for (int i = 0; i < 10; i++) upd(IDX_W'(20 + i), 1'(i % 2), (i < 3));
    #1;
    chk("stat_br_10", {32'd0, stat_br}, 64'd10);
    chk("stat_miss_3", {32'd0, stat_miss}, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
